// File: rtl/color_scan_if.sv
// Bundle of the colour-scan controller's request, counter and result signals.
// master = controller side, slave = environment (sensor counter, colour-order store, host).
interface color_scan_if;
  // start/cont are level requests sampled only in IDLE (or DONE for cont).
  // meas_start/meas_done form a pulse handshake: one meas_done per meas_start, with meas_freq
  // valid in the meas_done cycle. result_valid is a one-cycle strobe with no back-pressure.
  logic        start;
  logic        cont;
  logic        s2;
  logic        s3;
  logic        meas_start;
  logic        meas_done;
  logic [31:0] meas_freq;
  logic [31:0] red_freq;
  logic [31:0] green_freq;
  logic [31:0] blue_freq;
  logic [31:0] clear_freq;
  logic [1:0]  color;
  logic        result_valid;
  logic        busy;
  logic        timeout_err;
  logic [2:0]  state_dbg;

  modport master (
    input  start, cont, meas_done, meas_freq,
    output s2, s3, meas_start, red_freq, green_freq, blue_freq, clear_freq,
           color, result_valid, busy, timeout_err, state_dbg
  );

  modport slave (
    output start, cont, meas_done, meas_freq,
    input  s2, s3, meas_start, red_freq, green_freq, blue_freq, clear_freq,
           color, result_valid, busy, timeout_err, state_dbg
  );
endinterface

// File: rtl/color_scan_ctrl.sv
// Colour-sensor scan sequencer: settles each filter, measures it, classifies the dominant colour.
// Define COLOR_SCAN_CLEAR_EN to add the clear channel and its no-object gate.
module color_scan_ctrl #(
  parameter logic [31:0] SETTLE_CYCLES  = 32'd100000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000000,
  parameter logic [31:0] MIN_FREQ       = 32'd5000
) (
  input  logic         clk,
  input  logic         rst_n,
  color_scan_if.master bus
);

  typedef enum logic [2:0] {IDLE, SELECT, MEASURE, STORE, CLASSIFY, DONE} state_t;
  typedef enum logic [1:0] {CH_RED, CH_GREEN, CH_BLUE, CH_CLEAR} chan_t;

`ifdef COLOR_SCAN_CLEAR_EN
  localparam chan_t LAST_CH = CH_CLEAR;
`else
  localparam chan_t LAST_CH = CH_BLUE;
`endif

  state_t      state;
  chan_t       ch;
  chan_t       next_ch;
  logic [31:0] cnt;
  logic [31:0] meas_val;
  logic [1:0]  color_next;

  function automatic logic [1:0] filter_code(chan_t c);
    case (c)
      CH_RED:   return 2'b00;
      CH_GREEN: return 2'b11;
      CH_BLUE:  return 2'b01;
      default:  return 2'b10;
    endcase
  endfunction

  assign next_ch       = chan_t'(ch + 2'd1);
  assign bus.state_dbg = state;

  // Strict greater-than on both rivals makes any tie for the maximum fall through to 00.
  always_comb begin
    color_next = 2'b00;
    if (bus.red_freq > bus.green_freq && bus.red_freq > bus.blue_freq &&
        bus.red_freq > MIN_FREQ)
      color_next = 2'b01;
    else if (bus.green_freq > bus.red_freq && bus.green_freq > bus.blue_freq &&
             bus.green_freq > MIN_FREQ)
      color_next = 2'b10;
    else if (bus.blue_freq > bus.red_freq && bus.blue_freq > bus.green_freq &&
             bus.blue_freq > MIN_FREQ)
      color_next = 2'b11;
`ifdef COLOR_SCAN_CLEAR_EN
    if (bus.clear_freq <= MIN_FREQ)
      color_next = 2'b00;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ch               <= CH_RED;
      cnt              <= '0;
      meas_val         <= '0;
      bus.s2           <= 1'b0;
      bus.s3           <= 1'b0;
      bus.meas_start   <= 1'b0;
      bus.red_freq     <= '0;
      bus.green_freq   <= '0;
      bus.blue_freq    <= '0;
      bus.clear_freq   <= '0;
      bus.color        <= 2'b00;
      bus.result_valid <= 1'b0;
      bus.busy         <= 1'b0;
      bus.timeout_err  <= 1'b0;
    end else begin
      bus.meas_start   <= 1'b0;
      bus.result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start || bus.cont) begin
            state              <= SELECT;
            ch                 <= CH_RED;
            cnt                <= '0;
            {bus.s2, bus.s3}   <= filter_code(CH_RED);
            bus.busy           <= 1'b1;
            bus.timeout_err    <= 1'b0;
          end
        end
        SELECT: begin
          if (cnt == SETTLE_CYCLES - 32'd1) begin
            state          <= MEASURE;
            cnt            <= '0;
            bus.meas_start <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        MEASURE: begin
          // A done landing on the expiry cycle wins over the timeout.
          if (bus.meas_done) begin
            meas_val <= bus.meas_freq;
            state    <= STORE;
          end else if (cnt == TIMEOUT_CYCLES - 32'd1) begin
            meas_val        <= '0;
            bus.timeout_err <= 1'b1;
            state           <= STORE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        STORE: begin
          case (ch)
            CH_RED:   bus.red_freq   <= meas_val;
            CH_GREEN: bus.green_freq <= meas_val;
            CH_BLUE:  bus.blue_freq  <= meas_val;
            default: begin
`ifdef COLOR_SCAN_CLEAR_EN
              bus.clear_freq <= meas_val;
`endif
            end
          endcase
          if (ch == LAST_CH) begin
            state <= CLASSIFY;
          end else begin
            state            <= SELECT;
            ch               <= next_ch;
            cnt              <= '0;
            {bus.s2, bus.s3} <= filter_code(next_ch);
          end
        end
        CLASSIFY: begin
          bus.color        <= color_next;
          bus.result_valid <= 1'b1;
          state            <= DONE;
        end
        DONE: begin
          if (bus.cont) begin
            state            <= SELECT;
            ch               <= CH_RED;
            cnt              <= '0;
            {bus.s2, bus.s3} <= filter_code(CH_RED);
            bus.timeout_err  <= 1'b0;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/color_scan_ctrl.md
# color_scan_ctrl

Sequencer for the colour-sensor path. It steps the sensor filter select lines (s2/s3) through each channel, waits for the photodiode output to settle, and triggers one frequency-counter measurement per channel. It latches each result and classifies the dominant colour, then hands a single-cycle result strobe to the colour-order store. It replaces the free-running, `done`-clocked state update with a fully `clk`-synchronous, handshaked controller.

## Interface
- `SETTLE_CYCLES`, 100000: clk cycles held in each filter setting before measuring (1 ms at 100 MHz).
- `TIMEOUT_CYCLES`, 50000000: max clk cycles waiting for `meas_done` per channel.
- `MIN_FREQ`, 5000: dominant channel must exceed this count to be classified.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request for a scan; honoured only in IDLE.
- `cont` in 1: continuous mode; when 1, a new scan begins automatically after each result.
- `s2` out 1: filter select, MSB.
- `s3` out 1: filter select, LSB.
- `meas_start` out 1: one-cycle pulse that starts the frequency counter.
- `meas_done` in 1: one-cycle pulse, clk-synchronous; `meas_freq` is valid on that cycle.
- `meas_freq` in 32: measured count.
- `red_freq`, `green_freq`, `blue_freq`, `clear_freq` out 32 each: latched channel counts.
- `color` out 2: 00 none/white, 01 red, 10 green, 11 blue.
- `result_valid` out 1: one-cycle pulse when `color` and the latched counts are updated.
- `busy` out 1: high from scan accept until `result_valid`, inclusive.
- `timeout_err` out 1: sticky; set when any channel times out, cleared on the next accepted scan.

## Operation
- Filter codes on {s2,s3}: red 00, blue 01, clear 10, green 11.
- Channel order: red, green, blue, then clear (clear only with the macro enabled).
- States: IDLE, SELECT, MEASURE, STORE, CLASSIFY, DONE.
- IDLE: `start`=1, or `cont`=1, moves to SELECT on channel red. Moving to SELECT clears `timeout_err`.
- SELECT: drives the channel's filter code; holds for exactly `SETTLE_CYCLES` cycles, then goes to MEASURE.
- MEASURE: `meas_start`=1 on the first cycle only. On `meas_done` the FSM captures `meas_freq` and goes to STORE. If `TIMEOUT_CYCLES` cycles pass with no done, it stores 0, sets `timeout_err`, and goes to STORE.
- STORE: writes the captured value to that channel's `*_freq` register. Goes to SELECT for the next channel, or to CLASSIFY after the last channel.
- CLASSIFY: one cycle.
  - red if R>G and R>B and R>`MIN_FREQ`; green if G>R and G>B and G>`MIN_FREQ`; blue if B>R and B>G and B>`MIN_FREQ`.
  - Otherwise 00. Any tie for the maximum gives 00.
  - Comparisons are unsigned 32-bit.
- DONE: `result_valid`=1 for one cycle. Returns to IDLE, or to SELECT/red if `cont`=1.
- `meas_done` outside MEASURE is ignored.
- `start` while busy is ignored; it is not queued.
- `s2`/`s3` hold their last code in CLASSIFY, DONE and IDLE.

## Timing
- Reset values: s2=0, s3=0, meas_start=0, all `*_freq`=0, color=00, result_valid=0, busy=0, timeout_err=0, state IDLE.
- Reset asserted mid-scan aborts immediately to these values. No `result_valid` is produced for the aborted scan.
- `start` sampled at cycle 0 gives `busy`=1 and SELECT from cycle 1.
- Per channel: SETTLE_CYCLES + 1 (`meas_start`) + wait + 1 (STORE). wait = cycles from `meas_start` to `meas_done`, minimum 1.
- `result_valid` comes 2 cycles after the last STORE. `busy` falls the cycle after `result_valid`, unless `cont`=1.
- `meas_done` arriving in the same cycle as timeout expiry counts as done; the frequency is kept and there is no error.
- Settle and timeout counters are 32-bit and reset on every state entry, so there is no wrap-around.

## Configuration
- `COLOR_SCAN_CLEAR_EN` defined:
  - a fourth channel (clear, code 10) is measured after blue;
  - CLASSIFY forces color=00 when `clear_freq` ≤ `MIN_FREQ` (no object present).
- Undefined:
  - three channels only;
  - `clear_freq` stays 0;
  - the clear gate is absent.

## Test plan
- SETTLE_CYCLES=4; `start` pulse; counter model returns R=9000, G=3000, B=4000 -> color=01, result_valid one pulse, {s2,s3} sequence 00, 11, 01, and `busy` low afterwards.
- R=6000, G=6000, B=1000 -> color=00 (tie). R=4000, G=3000, B=2000 -> color=00 (below MIN_FREQ).
- Counter model never asserts done on green, with TIMEOUT_CYCLES=20 -> green_freq=0 and timeout_err=1. The next `start` clears timeout_err.
- `cont`=1 with blue-dominant counts (B=8000) -> back-to-back result_valid pulses, each color=11, with no IDLE gap. Spurious `start` pulses and `meas_done` pulses in SELECT have no effect.
- `rst_n` low during MEASURE of blue -> all outputs at reset values in the same cycle; no result_valid; a later `start` completes normally.
- With `COLOR_SCAN_CLEAR_EN`: R=9000, clear=3000 -> color=00. R=9000, clear=20000 -> color=01, and {s2,s3}=10 is observed during the fourth channel.
